// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the packet-locked weighted round-robin arbiter.
package wrr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam int N_REQ_DEF = 16;

    // Width of a binary requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W_DEF = id_w(N_REQ_DEF);

endpackage

// File: rtl/rr_pick_first.sv
// Rotating first-set picker: first request at or above ptr, wrapping modulo N.
module rr_pick_first
    import wrr_arb_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic found;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found     = 1'b1;
                onehot[k] = 1'b1;
                idx       = IW'(k);
            end
        end
    end

endmodule

// File: rtl/wrr_lock_arbiter.sv
// Packet-locked weighted round-robin arbiter; the owner keeps the grant for
// up to <weight> whole packets, then the pointer moves past it.
module wrr_lock_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int N_REQ = 16,
    parameter int W_WT  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_last,
    input  logic [N_REQ*W_WT-1:0]   i_weight,
    input  logic                    i_ready,
    output logic [N_REQ-1:0]        o_grant,
    output logic [id_w(N_REQ)-1:0]  o_grant_id,
    output logic                    o_grant_vld
);

    localparam int IW = id_w(N_REQ);

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     id_q, id_d;
    logic [W_WT-1:0]   credit_q, credit_d;
    logic              bound_q, bound_d;
    logic              vld_q, vld_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  pick_oh;
    logic [IW-1:0]     pick_idx;
    logic [W_WT-1:0]   wt_pick;
    logic              xfer;
    logic              rel;

    rr_pick_first #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req    (i_req),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign wt_pick = i_weight[int'(pick_idx)*W_WT +: W_WT];
    assign xfer    = (state_q == LOCK) && i_req[id_q] && i_ready;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        credit_d = credit_q;
        bound_d  = bound_q;
        vld_d    = vld_q;
        grant_d  = grant_q;
        rel      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|i_req) begin
                    state_d  = LOCK;
                    grant_d  = pick_oh;
                    id_d     = pick_idx;
                    vld_d    = 1'b1;
                    bound_d  = 1'b0;
                    // A zero weight still earns one packet per round.
                    credit_d = (wt_pick == '0) ? W_WT'(1) : wt_pick;
                end
            end
            LOCK: begin
                if (xfer) begin
                    if (i_last[id_q]) begin
                        bound_d = 1'b1;
                        if (credit_q != '0) credit_d = credit_q - 1'b1;
                        rel = (credit_q <= W_WT'(1));
                    end else begin
                        bound_d = 1'b0;
                    end
                end else if (bound_q && !i_req[id_q]) begin
                    rel = 1'b1;
                end
                if (rel) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    id_d     = '0;
                    vld_d    = 1'b0;
                    bound_d  = 1'b0;
                    credit_d = '0;
                    ptr_d    = (id_q == IW'(N_REQ-1)) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            credit_q <= '0;
            bound_q  <= 1'b0;
            vld_q    <= 1'b0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            credit_q <= credit_d;
            bound_q  <= bound_d;
            vld_q    <= vld_d;
            grant_q  <= grant_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_grant_id  = id_q;
    assign o_grant_vld = vld_q;

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Directed bench for wrr_lock_arbiter: a 16-requester and a 4-requester instance.
module tb_wrr_lock_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [15:0] req, last;
    logic [63:0] wt;
    logic        rdy;
    logic [15:0] gnt;
    logic [3:0]  gid;
    logic        gv;

    logic [3:0]  req4, last4;
    logic [15:0] wt4;
    logic        rdy4;
    logic [3:0]  gnt4;
    logic [1:0]  gid4;
    logic        gv4;

    int n_chk = 0;
    int n_fail = 0;

    int seq34[11] = '{0, 0, 0, -1, 1, -1, 2, -1, 3, -1, 0};
    int seq36[12] = '{0, -1, 1, -1, 2, -1, 3, -1, 0, -1, 1, -1};

    always #5 clk = ~clk;

    wrr_lock_arbiter #(.N_REQ(16), .W_WT(4)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_last      (last),
        .i_weight    (wt),
        .i_ready     (rdy),
        .o_grant     (gnt),
        .o_grant_id  (gid),
        .o_grant_vld (gv)
    );

    wrr_lock_arbiter #(.N_REQ(4), .W_WT(4)) u_dut4 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req4),
        .i_last      (last4),
        .i_weight    (wt4),
        .i_ready     (rdy4),
        .o_grant     (gnt4),
        .o_grant_id  (gid4),
        .o_grant_vld (gv4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // id < 0 means no grant expected.
    task automatic chk16(input string tag, input int id);
        if (id < 0) begin
            chk({tag, "_grant"}, 32'(gnt), 32'd0);
            chk({tag, "_id"}, 32'(gid), 32'd0);
            chk({tag, "_vld"}, 32'(gv), 32'd0);
        end else begin
            chk({tag, "_grant"}, 32'(gnt), 32'd1 << id);
            chk({tag, "_id"}, 32'(gid), 32'(id));
            chk({tag, "_vld"}, 32'(gv), 32'd1);
        end
    endtask

    task automatic chk4(input string tag, input int id);
        if (id < 0) begin
            chk({tag, "_grant"}, 32'(gnt4), 32'd0);
            chk({tag, "_id"}, 32'(gid4), 32'd0);
            chk({tag, "_vld"}, 32'(gv4), 32'd0);
        end else begin
            chk({tag, "_grant"}, 32'(gnt4), 32'd1 << id);
            chk({tag, "_id"}, 32'(gid4), 32'(id));
            chk({tag, "_vld"}, 32'(gv4), 32'd1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        rdy   = 1'b0;
        req4  = '0;
        last4 = '0;
        rdy4  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        req   = '0;
        last  = '0;
        rdy   = 1'b0;
        wt    = 64'h1111_1111_1111_1111;
        req4  = '0;
        last4 = '0;
        rdy4  = 1'b0;
        wt4   = 16'h1111;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk16("rst", -1);
        chk4("rst4", -1);
        repeat (2) tick();
        rst_n = 1'b1;

        // Full rotation, weight 1, single-beat packets, one bubble per grant.
        req  = 16'hFFFF;
        last = 16'hFFFF;
        rdy  = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            chk16("rot", k % 16);
            tick();
            chk16("rot_bub", -1);
        end

        // Weights {3,1,1,1}: three back-to-back packets for requester 0.
        do_reset();
        wt4   = 16'h1113;
        req4  = 4'hF;
        last4 = 4'hF;
        rdy4  = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk4("wrr", seq34[i]);
        end

        // Weight 0 on requester 1 behaves as weight 1.
        do_reset();
        wt4   = 16'h1101;
        req4  = 4'hF;
        last4 = 4'hF;
        rdy4  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk4("wt0", seq36[i]);
        end

        // Owner 2, four-beat packet under toggling ready, intruder on 5.
        do_reset();
        wt   = 64'h1111_1111_1111_1111;
        req  = 16'h0004;
        tick();
        chk16("pkt_g", 2);
        rdy = 1'b1;
        tick();
        chk16("pkt_b1", 2);
        rdy = 1'b0;
        req = 16'h0024;
        tick();
        chk16("pkt_w1", 2);
        rdy = 1'b1;
        tick();
        chk16("pkt_b2", 2);
        rdy = 1'b0;
        tick();
        chk16("pkt_w2", 2);
        rdy = 1'b1;
        tick();
        chk16("pkt_b3", 2);
        rdy  = 1'b0;
        last = 16'h0004;
        tick();
        chk16("pkt_lastnr", 2);
        rdy = 1'b1;
        tick();
        chk16("pkt_rel", -1);
        last = '0;
        tick();
        chk16("pkt_next", 5);

        // Weight 4 owner: stall, one packet, then drop at the boundary.
        do_reset();
        wt  = 64'h1111_1111_1111_4111;
        req = 16'h0208;
        rdy = 1'b1;
        tick();
        chk16("bnd_g", 3);
        req = 16'h0200;
        tick();
        chk16("bnd_stall", 3);
        req  = 16'h0208;
        last = 16'h0008;
        tick();
        chk16("bnd_pkt", 3);
        req  = 16'h0200;
        last = '0;
        tick();
        chk16("bnd_rel", -1);
        req = 16'h0202;
        tick();
        chk16("bnd_ptr", 9);

        // Reset mid-packet with owner 7.
        do_reset();
        wt  = 64'h1111_1111_1111_1111;
        req = 16'h0080;
        rdy = 1'b1;
        tick();
        chk16("mid_g", 7);
        tick();
        chk16("mid_beat", 7);
        #2 rst_n = 1'b0;
        #1;
        chk16("mid_async", -1);
        repeat (2) tick();
        chk16("mid_hold", -1);
        rst_n = 1'b1;
        req   = 16'h0081;
        tick();
        chk16("mid_first", 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
